// File: rtl/nn_pkg.sv
// Shared widths, address width and FSM state encoding for the neuron datapath.
package nn_pkg;

  localparam int unsigned DefWidth    = 8;
  localparam int unsigned DefActWidth = 8;
  localparam int unsigned DefAccWidth = 32;
  localparam int unsigned DefOutWidth = 8;
  localparam int unsigned AddrWidth   = 16;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StRun    = 2'd1;
  localparam logic [1:0] StDrain  = 2'd2;
  localparam logic [1:0] StFinish = 2'd3;

endpackage

// File: rtl/post_act.sv
// Output stage of a neuron: bias add, ReLU, right shift and unsigned saturation.
module post_act #(
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned SHIFT     = 0,
  parameter int unsigned OUT_WIDTH = 8
) (
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic [ACC_WIDTH-1:0] bias,
  output logic [OUT_WIDTH-1:0] res
);

  localparam logic [ACC_WIDTH-1:0] MaxVal = (ACC_WIDTH'(1) << OUT_WIDTH) - ACC_WIDTH'(1);

  logic [ACC_WIDTH-1:0] sum;
  logic [ACC_WIDTH-1:0] shifted;

  assign sum = acc + bias;

  always_comb begin
    res     = '0;
    shifted = sum >> SHIFT;
    // Negative sums clamp to zero; shifting only ever sees non-negative values.
    if (!sum[ACC_WIDTH-1]) begin
      if (shifted > MaxVal) begin
        res = '1;
      end else begin
        res = shifted[OUT_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// Sequencing MAC for one neuron: sweeps the weight/activation address space,
// accumulates signed products and registers the post-processed activation.
module neuron_mac
  import nn_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned ACT_WIDTH = DefActWidth,
  parameter int unsigned N_INPUTS  = 784,
  parameter int unsigned ACC_WIDTH = DefAccWidth,
  parameter int unsigned SHIFT     = 0,
  parameter int unsigned OUT_WIDTH = DefOutWidth
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic signed [ACC_WIDTH-1:0] bias,
  output logic [AddrWidth-1:0]        addr_rd,
  input  logic signed [WIDTH-1:0]     weight_in,
  input  logic [ACT_WIDTH-1:0]        act_in,
  output logic                        busy,
  output logic [OUT_WIDTH-1:0]        result,
  output logic                        result_valid
);

  localparam int unsigned          ProdWidth = WIDTH + ACT_WIDTH + 1;
  localparam logic [AddrWidth-1:0] LastAddr  = AddrWidth'(N_INPUTS - 1);

  logic [1:0]                  state_q, state_d;
  logic [AddrWidth-1:0]        addr_q, addr_d;
  logic                        dv_q, dv_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] bias_q, bias_d;
  logic [OUT_WIDTH-1:0]        result_q, result_d;
  logic                        valid_q, valid_d;

  logic signed [ProdWidth-1:0] w_ext, a_ext, prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic [OUT_WIDTH-1:0]        post_res;

  // Activation is zero-extended so the multiply stays signed without losing its MSB.
  assign w_ext    = ProdWidth'(weight_in);
  assign a_ext    = ProdWidth'({1'b0, act_in});
  assign prod     = w_ext * a_ext;
  assign prod_ext = ACC_WIDTH'(prod);

  post_act #(
    .ACC_WIDTH(ACC_WIDTH),
    .SHIFT    (SHIFT),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_post_act (
    .acc (acc_q),
    .bias(bias_q),
    .res (post_res)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    acc_d   = acc_q;
    bias_d  = bias_q;
    if (dv_q) begin
      acc_d = acc_q + prod_ext;
    end
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          addr_d  = '0;
          acc_d   = '0;
          bias_d  = bias;
        end
      end
      StRun: begin
        if (addr_q == LastAddr) begin
          state_d = StDrain;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + AddrWidth'(1);
        end
      end
      StDrain:  state_d = StFinish;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Data returns one cycle after its address, so dv trails the RUN state by one edge.
  assign dv_d     = (state_q == StRun);
  assign valid_d  = (state_q == StFinish);
  assign result_d = valid_d ? post_res : result_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      dv_q     <= 1'b0;
      acc_q    <= '0;
      bias_q   <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      dv_q     <= dv_d;
      acc_q    <= acc_d;
      bias_q   <= bias_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign addr_rd      = addr_q;
  assign busy         = (state_q != StIdle);
  assign result       = result_q;
  assign result_valid = valid_q;

endmodule
